// File: rtl/latch_readout_pkg.sv
// Shared types and constants for the latch readout transmitter.
// Optional parity support is enabled with LATCH_READOUT_PARITY_EN.
package latch_readout_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Number of serial bit slots in one frame: start + payload + (parity) + stop.
  function automatic int unsigned frame_bits(input int unsigned data_w, input bit parity);
    return parity ? data_w + 3 : data_w + 2;
  endfunction

endpackage

// File: rtl/latch_readout_baud_div.sv
// Bit-period divider: emits a one-cycle bit_tick every BIT_DIV cycles while running.
// Cleared synchronously by clear, asynchronously by rst.
module latch_readout_baud_div #(
  parameter int unsigned BIT_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic bit_tick
);

  localparam int unsigned CntW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BIT_DIV - 1);

  logic [CntW-1:0] cnt_q;

  assign bit_tick = run && (cnt_q == CntMax);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run) begin
      if (cnt_q == CntMax) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/latch_readout_tx.sv
// Stored word with framed serial readout (start, LSB-first data, optional parity, stop).
// Define LATCH_READOUT_PARITY_EN to insert an even-parity bit between data and stop.
module latch_readout_tx
  import latch_readout_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned BIT_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  output logic [DATA_W-1:0] q,
  output logic              ser_out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BitW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BitW-1:0] BitMax = BitW'(DATA_W - 1);

  state_e            state_q;
  logic [BitW-1:0]   bit_cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_nxt;
  logic [DATA_W-1:0] load_word;
  logic              load;
  logic              bit_tick;
`ifdef LATCH_READOUT_PARITY_EN
  logic              parity_q;
`endif

  assign load      = (state_q == StIdle) && rd_req;
  // A write on the request edge is carried by the frame (write-through).
  assign load_word = wr_en ? wr_data : q;
  assign shift_nxt = shift_q >> 1;

  latch_readout_baud_div #(
    .BIT_DIV(BIT_DIV)
  ) u_baud_div (
    .clk     (clk),
    .rst     (rst),
    .clear   (load),
    .run     (busy),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q         <= '0;
      ser_out   <= IDLE_LEVEL;
      busy      <= 1'b0;
      done      <= 1'b0;
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
`ifdef LATCH_READOUT_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      if (wr_en) begin
        q <= wr_data;
      end
      done <= 1'b0;

      case (state_q)
        StIdle: begin
          if (rd_req) begin
            state_q   <= StStart;
            shift_q   <= load_word;
            bit_cnt_q <= '0;
            ser_out   <= START_LEVEL;
            busy      <= 1'b1;
`ifdef LATCH_READOUT_PARITY_EN
            parity_q  <= ^load_word;
`endif
          end
        end

        StStart: begin
          if (bit_tick) begin
            state_q <= StData;
            ser_out <= shift_q[0];
          end
        end

        StData: begin
          if (bit_tick) begin
            if (bit_cnt_q == BitMax) begin
`ifdef LATCH_READOUT_PARITY_EN
              state_q <= StParity;
              ser_out <= parity_q;
`else
              state_q <= StStop;
              ser_out <= STOP_LEVEL;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + BitW'(1);
              shift_q   <= shift_nxt;
              ser_out   <= shift_nxt[0];
            end
          end
        end

        StParity: begin
`ifdef LATCH_READOUT_PARITY_EN
          if (bit_tick) begin
            state_q <= StStop;
            ser_out <= STOP_LEVEL;
          end
`else
          state_q <= StIdle;
          ser_out <= IDLE_LEVEL;
          busy    <= 1'b0;
`endif
        end

        StStop: begin
          if (bit_tick) begin
            state_q <= StIdle;
            ser_out <= IDLE_LEVEL;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end

        default: begin
          state_q <= StIdle;
          ser_out <= IDLE_LEVEL;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latch_readout_tx.sv
// Directed self-checking bench for latch_readout_tx (DATA_W=8, BIT_DIV=4).
// With LATCH_READOUT_PARITY_EN a second BIT_DIV=1 instance exercises the parity bit.
module tb_latch_readout_tx;
  import latch_readout_pkg::*;

  localparam int DW = 8;
  localparam int BD = 4;
`ifdef LATCH_READOUT_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FCYC = int'(frame_bits(DW, PAR)) * BD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_req = 1'b0;
  logic [DW-1:0] q;
  logic          ser_out;
  logic          busy;
  logic          done;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  latch_readout_tx #(
    .DATA_W (DW),
    .BIT_DIV(BD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .rd_req (rd_req),
    .q      (q),
    .ser_out(ser_out),
    .busy   (busy),
    .done   (done)
  );

`ifdef LATCH_READOUT_PARITY_EN
  logic          p_wr_en = 1'b0;
  logic [DW-1:0] p_wr_data = '0;
  logic          p_rd_req = 1'b0;
  logic [DW-1:0] p_q;
  logic          p_ser_out;
  logic          p_busy;
  logic          p_done;

  latch_readout_tx #(
    .DATA_W (DW),
    .BIT_DIV(1)
  ) dut_par (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (p_wr_en),
    .wr_data(p_wr_data),
    .rd_req (p_rd_req),
    .q      (p_q),
    .ser_out(p_ser_out),
    .busy   (p_busy),
    .done   (p_done)
  );
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level for bit slot b of a frame carrying w.
  function automatic logic exp_bit(input logic [DW-1:0] w, input int b, input bit par);
    if (b == 0) return 1'b0;
    if (b <= DW) return w[b-1];
    if (par && b == DW + 1) return ^w;
    return 1'b1;
  endfunction

  task automatic do_write(input logic [DW-1:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Called in cycle 0 of a frame (just after the request edge).
  task automatic run_frame(input logic [DW-1:0] w, input int wr_at, input logic [DW-1:0] wr_val,
                           input int rq_a, input int rq_b, input bit rq_end, input int abort_at);
    for (int c = 0; c < FCYC; c++) begin
      if (c == abort_at) begin
        #2 rst = 1'b1;
        #1;
        check("abort_ser", ser_out, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_q", q, 0);
        return;
      end
      check($sformatf("ser_c%0d", c), ser_out, exp_bit(w, c / BD, PAR));
      check($sformatf("busy_c%0d", c), busy, 1);
      check($sformatf("done_c%0d", c), done, 0);
      wr_en   = (c == wr_at);
      wr_data = wr_val;
      rd_req  = (c == rq_a) || (c == rq_b);
      @(negedge clk);
    end
    wr_en  = 1'b0;
    rd_req = 1'b0;
    check("end_done", done, 1);
    check("end_busy", busy, 0);
    check("end_ser", ser_out, 1);
    rd_req = rq_end;
    @(negedge clk);
    rd_req = 1'b0;
    check("done_pulse_width", done, 0);
  endtask

`ifdef LATCH_READOUT_PARITY_EN
  task automatic par_frame(input logic [DW-1:0] w);
    p_wr_en   = 1'b1;
    p_wr_data = w;
    p_rd_req  = 1'b1;
    @(negedge clk);
    p_wr_en   = 1'b0;
    p_rd_req  = 1'b0;
    for (int c = 0; c < 11; c++) begin
      check($sformatf("par_ser_c%0d", c), p_ser_out, exp_bit(w, c, 1'b1));
      check($sformatf("par_busy_c%0d", c), p_busy, 1);
      @(negedge clk);
    end
    check("par_done", p_done, 1);
    check("par_idle", p_busy, 0);
    @(negedge clk);
  endtask
`endif

  initial begin
    // Reset and asynchronous re-assertion mid-cycle.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_write(8'h77);
    check("write_q", q, 8'h77);
    #2 rst = 1'b1;
    #1;
    check("rst_q", q, 0);
    check("rst_ser", ser_out, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("idle_ser", ser_out, 1);
      @(negedge clk);
    end

    // Basic frame.
    do_write(8'hA5);
    rd_req = 1'b1;
    @(negedge clk);
    run_frame(8'hA5, -1, 8'h00, -1, -1, 1'b0, -1);
    check("basic_q", q, 8'hA5);

    // Write-through on the request edge, then a write mid-frame.
    do_write(8'h00);
    check("zero_q", q, 8'h00);
    wr_en   = 1'b1;
    wr_data = 8'h3C;
    rd_req  = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
    check("wt_q", q, 8'h3C);
    run_frame(8'h3C, 10, 8'hFF, -1, -1, 1'b0, -1);
    check("mid_write_q", q, 8'hFF);

    // Ignored requests, then back-to-back frames.
    rd_req = 1'b1;
    @(negedge clk);
    run_frame(8'hFF, -1, 8'h00, 5, 20, 1'b1, -1);
    run_frame(8'hFF, -1, 8'h00, -1, -1, 1'b0, -1);
    check("idle_after_b2b", busy, 0);

    // Abort during data bit 3, then a clean frame of the reset word.
    do_write(8'h55);
    rd_req = 1'b1;
    @(negedge clk);
    run_frame(8'h55, -1, 8'h00, -1, -1, 1'b0, 4 * BD + 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("post_abort_done", done, 0);
      check("post_abort_ser", ser_out, 1);
      @(negedge clk);
    end
    rd_req = 1'b1;
    @(negedge clk);
    run_frame(8'h00, -1, 8'h00, -1, -1, 1'b0, -1);

`ifdef LATCH_READOUT_PARITY_EN
    par_frame(8'h07);
    par_frame(8'h03);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
